io_in_port: RTL and testbench

Input-port controller that feeds the CPU's `INPUT` bus and `INTR_in` line, replacing bench-driven stimulus with real hardware. An external producer pushes bytes through a valid/ready handshake into a small FIFO. The block presents the FIFO head on `INPUT`, pops one byte per CPU `IN` read strobe, and raises one interrupt pulse per burst of arriving data.

---
 rtl/io_pkg.sv | 13 +
 rtl/byte_fifo.sv | 63 ++++++
 rtl/io_in_port.sv | 93 +++++++++
 tb/tb_io_in_port.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and defaults for the CPU input-port controller.
package io_pkg;

  localparam int IO_DATA_W     = 8;
  localparam int IO_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    SERVICE = 2'd2
  } intr_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO: register array with asynchronous read. Pointers wrap naturally
// (power-of-two depth); full and empty are told apart by the count alone.
module byte_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/io_in_port.sv
// CPU input port: buffers producer bytes, presents the head on INPUT, pops on IN
// strobes and raises one fixed-length interrupt pulse per burst of arriving data.
module io_in_port
  import io_pkg::*;
#(
  parameter  int DATA_W   = IO_DATA_W,
  parameter  int DEPTH    = IO_FIFO_DEPTH,
  parameter  int INTR_LEN = 2,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ext_valid,
  input  logic [DATA_W-1:0] ext_data,
  output logic              ext_ready,
  input  logic              in_rd,
  output logic [DATA_W-1:0] INPUT,
  output logic              INTR_out,
  output logic [CW-1:0]     count,
  output logic              underflow
);

  localparam int PW = (INTR_LEN > 1) ? $clog2(INTR_LEN) : 1;

  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic              push, pop;

  intr_state_t       state_q, state_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic              underflow_q, underflow_d;

  assign ext_ready = !fifo_full;
  assign push      = ext_valid && !fifo_full;
  assign pop       = in_rd && !fifo_empty;

  byte_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (ext_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign INPUT     = fifo_empty ? '0 : fifo_dout;
  assign count     = fifo_count;
  assign underflow = underflow_q;
  assign INTR_out  = (state_q == PULSE);

  always_comb begin
    underflow_d = underflow_q | (in_rd && fifo_empty);
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = PULSE;
          pcnt_d  = PW'(INTR_LEN - 1);
        end
      end
      PULSE: begin
        // The pulse always runs its full length, even if the FIFO drains.
        if (pcnt_q == '0) state_d = SERVICE;
        else              pcnt_d  = pcnt_q - PW'(1);
      end
      SERVICE: begin
        if (fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      pcnt_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_io_in_port.sv
// Bench for io_in_port: directed vector table, corner-case sequences and random
// traffic checked against a queue-based reference model.
module tb_io_in_port;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int INTR_LEN = 2;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic              CLK = 1'b0;
  logic              RST;
  logic              ext_valid;
  logic [DATA_W-1:0] ext_data;
  logic              ext_ready;
  logic              in_rd;
  logic [DATA_W-1:0] INPUT;
  logic              INTR_out;
  logic [CW-1:0]     count;
  logic              underflow;

  io_in_port #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .INTR_LEN (INTR_LEN)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ext_valid (ext_valid),
    .ext_data  (ext_data),
    .ext_ready (ext_ready),
    .in_rd     (in_rd),
    .INPUT     (INPUT),
    .INTR_out  (INTR_out),
    .count     (count),
    .underflow (underflow)
  );

  always #5 CLK = ~CLK;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: byte queue, pulse countdown, "burst being serviced" flag.
  logic [7:0] mq[$];
  int         pulse_left = 0;
  bit         busy = 1'b0;
  bit         m_uf = 1'b0;

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       rd;
    int         cnt;
    logic [7:0] din;
    logic       intr;
    logic       rdy;
    logic       uf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [7:0] d, input logic rd);
    int old_size;
    old_size = mq.size();
    if (r) begin
      mq.delete();
      pulse_left = 0;
      busy = 1'b0;
      m_uf = 1'b0;
    end else begin
      if (pulse_left > 0) pulse_left--;
      else if (busy) begin
        if (old_size == 0) busy = 1'b0;
      end else if (old_size != 0) begin
        busy = 1'b1;
        pulse_left = INTR_LEN;
      end
      if (rd && old_size == 0) m_uf = 1'b1;
      if (rd && old_size != 0) void'(mq.pop_front());
      if (v && old_size < DEPTH) mq.push_back(d);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic rd);
    RST = r;
    ext_valid = v;
    ext_data = d;
    in_rd = rd;
    @(posedge CLK);
    model_edge(r, v, d, rd);
    #1;
    $display("[TB] t=%0t rst=%0b v=%0b d=%02h rd=%0b -> cnt=%0d in=%02h intr=%0b rdy=%0b uf=%0b",
             $time, r, v, d, rd, count, INPUT, INTR_out, ext_ready, underflow);
  endtask

  task automatic check_model(input string tag);
    logic [7:0] e_in;
    e_in = (mq.size() != 0) ? mq[0] : 8'h00;
    chk({tag, "_count"}, 32'(count), 32'(mq.size()));
    chk({tag, "_input"}, 32'(INPUT), 32'(e_in));
    chk({tag, "_intr"}, 32'(INTR_out), 32'(pulse_left > 0));
    chk({tag, "_ready"}, 32'(ext_ready), 32'(mq.size() < DEPTH));
    chk({tag, "_underflow"}, 32'(underflow), 32'(m_uf));
  endtask

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic rd,
                     input int c, input logic [7:0] di, input logic i, input logic rdy,
                     input logic uf);
    vec_t e;
    e.rst = r; e.v = v; e.d = d; e.rd = rd;
    e.cnt = c; e.din = di; e.intr = i; e.rdy = rdy; e.uf = uf;
    vecs.push_back(e);
  endtask

  initial begin
    int rises;
    logic prev;
    RST = 1'b1;
    ext_valid = 1'b0;
    ext_data = '0;
    in_rd = 1'b0;

    //   rst v  d      rd   cnt in     intr rdy uf
    add(1, 1, 8'hAA, 0,   0, 8'h00, 0, 1, 0);   // reset with producer active
    add(1, 1, 8'hAA, 0,   0, 8'h00, 0, 1, 0);
    add(0, 1, 8'h06, 0,   1, 8'h06, 0, 1, 0);   // single byte, edge n
    add(0, 0, 8'h00, 0,   1, 8'h06, 1, 1, 0);   // n+1: pulse
    add(0, 0, 8'h00, 0,   1, 8'h06, 1, 1, 0);
    add(0, 0, 8'h00, 0,   1, 8'h06, 0, 1, 0);   // service
    add(0, 0, 8'h00, 1,   0, 8'h00, 0, 1, 0);   // read it
    add(0, 0, 8'h00, 0,   0, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 0,   0, 8'h00, 0, 1, 0);
    add(0, 1, 8'h01, 0,   1, 8'h01, 0, 1, 0);   // fill 01..05
    add(0, 1, 8'h02, 0,   2, 8'h01, 1, 1, 0);
    add(0, 1, 8'h03, 0,   3, 8'h01, 1, 1, 0);
    add(0, 1, 8'h04, 0,   4, 8'h01, 0, 0, 0);
    add(0, 1, 8'h05, 0,   4, 8'h01, 0, 0, 0);   // held off
    add(0, 1, 8'h05, 1,   3, 8'h02, 0, 1, 0);   // full + read: pop only
    add(0, 1, 8'h05, 0,   4, 8'h02, 0, 0, 0);   // 05 accepted now
    add(0, 0, 8'h00, 1,   3, 8'h03, 0, 1, 0);
    add(0, 0, 8'h00, 1,   2, 8'h04, 0, 1, 0);
    add(0, 0, 8'h00, 1,   1, 8'h05, 0, 1, 0);
    add(0, 0, 8'h00, 1,   0, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 0,   0, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 1,   0, 8'h00, 0, 1, 1);   // underflow
    add(0, 1, 8'h07, 1,   1, 8'h07, 0, 1, 1);   // empty push+read: push wins
    add(0, 0, 8'h00, 0,   1, 8'h07, 1, 1, 1);
    add(0, 0, 8'h00, 1,   0, 8'h00, 1, 1, 1);   // drained mid-pulse
    add(0, 0, 8'h00, 0,   0, 8'h00, 0, 1, 1);
    add(0, 0, 8'h00, 0,   0, 8'h00, 0, 1, 1);
    add(0, 1, 8'h08, 0,   1, 8'h08, 0, 1, 1);
    add(0, 0, 8'h00, 0,   1, 8'h08, 1, 1, 1);   // first pulse cycle
    add(1, 1, 8'hAA, 1,   0, 8'h00, 0, 1, 0);   // reset mid-pulse
    add(0, 1, 8'h09, 0,   1, 8'h09, 0, 1, 0);
    add(0, 0, 8'h00, 0,   1, 8'h09, 1, 1, 0);
    add(0, 0, 8'h00, 0,   1, 8'h09, 1, 1, 0);
    add(0, 0, 8'h00, 0,   1, 8'h09, 0, 1, 0);
    add(0, 0, 8'h00, 1,   0, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 0,   0, 8'h00, 0, 1, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].rd);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_input", i), 32'(INPUT), 32'(vecs[i].din));
      chk($sformatf("vec%0d_intr", i), 32'(INTR_out), 32'(vecs[i].intr));
      chk($sformatf("vec%0d_ready", i), 32'(ext_ready), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].uf));
    end

    // Steady count=2 with concurrent push+pop across pointer wrap.
    rises = 0;
    prev = INTR_out;
    step(0, 1, 8'hA0, 0);
    check_model("wrap");
    if (INTR_out && !prev) rises++;
    prev = INTR_out;
    step(0, 1, 8'hA1, 0);
    check_model("wrap");
    if (INTR_out && !prev) rises++;
    prev = INTR_out;
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 8'(8'hB0 + k), 1);
      check_model("wrap");
      if (INTR_out && !prev) rises++;
      prev = INTR_out;
    end
    chk("wrap_count_final", 32'(count), 32'd2);
    chk("wrap_head_final", 32'(INPUT), 32'h0000_00B8);
    chk("wrap_intr_pulses", 32'(rises), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 8'h00, (k < 2) ? 1'b1 : 1'b0);
      check_model("drain");
    end

    // Random traffic with shifting read/write bias to reach full and empty.
    for (int n = 0; n < 600; n++) begin
      logic r, v, rd;
      int phase;
      phase = (n / 50) % 3;
      r  = ($urandom_range(0, 79) == 0);
      v  = (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rd = (phase == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      step(r, v, 8'($urandom), rd);
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
